// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Combinational helpers only; no latency and no flow control.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int         ITER        = 32;
    localparam logic [4:0] EXC_MUL_OVF = 5'd4;
    localparam logic [4:0] EXC_DIV     = 5'd5;

    // Two's-complement magnitude; 0x80000000 maps to 2^31 read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
// Purely combinational, zero latency; no flow control.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] b_mag_i,
    output logic [63:0] acc_o
);

    logic [32:0] sum;
    logic [63:0] sh;
    logic [32:0] diff;

    always_comb begin
        sum   = '0;
        sh    = '0;
        diff  = '0;
        acc_o = acc_i;
        if (is_div_i) begin
            // Remainder lives in the high word, dividend/quotient in the low word.
            sh   = {acc_i[62:0], 1'b0};
            diff = {1'b0, sh[63:32]} - {1'b0, b_mag_i};
            if (!diff[32]) begin
                acc_o = {diff[31:0], sh[31:1], 1'b1};
            end else begin
                acc_o = sh;
            end
        end else begin
            // Partial product in the high word, multiplier bits shift out the bottom.
            sum   = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, b_mag_i} : 33'd0);
            acc_o = {sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed 32x32 multiply (low word) and divide (quotient), one bit per cycle.
// Latency 33 cycles start->ready (2 for divide by zero); starts are ignored while busy.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        start_mul,
    input  logic        start_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] result,
    output logic        ready,
    output logic        busy,
    output logic        stall,
    output logic        exception,
    output logic [4:0]  exc_code
);

    state_t      state_q,    state_d;
    logic [4:0]  count_q,    count_d;
    logic [63:0] acc_q,      acc_d;
    logic [31:0] b_mag_q,    b_mag_d;
    logic        sign_q,     sign_d;
    logic        is_div_q,   is_div_d;
    logic        div_zero_q, div_zero_d;
    logic        div_ovf_q,  div_ovf_d;

    logic [63:0] step_acc;
    logic [63:0] prod_signed;
    logic [31:0] quot_signed;
    logic        mul_ovf;
    logic        done;

    muldiv_step u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .b_mag_i  (b_mag_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        b_mag_d    = b_mag_q;
        sign_d     = sign_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        div_ovf_d  = div_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_mul || start_div) begin
                    acc_d      = {32'd0, abs32(operand_a)};
                    b_mag_d    = abs32(operand_b);
                    sign_d     = operand_a[31] ^ operand_b[31];
                    count_d    = '0;
                    is_div_d   = !start_mul;
                    div_zero_d = !start_mul && (operand_b == 32'd0);
                    div_ovf_d  = !start_mul && (operand_a == 32'h8000_0000)
                                            && (operand_b == 32'hFFFF_FFFF);
                    state_d    = start_mul ? ST_MUL : ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (state_q == ST_DIV && div_zero_q) begin
                    state_d = ST_DONE;
                end else begin
                    acc_d   = step_acc;
                    count_d = count_q + 5'd1;
                    if (count_q == 5'(ITER - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            b_mag_q    <= '0;
            sign_q     <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            b_mag_q    <= b_mag_d;
            sign_q     <= sign_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            div_ovf_q  <= div_ovf_d;
        end
    end

    assign done        = (state_q == ST_DONE);
    assign prod_signed = sign_q ? (~acc_q + 64'd1) : acc_q;
    assign quot_signed = sign_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign mul_ovf     = (prod_signed[63:32] != {32{prod_signed[31]}});

    always_comb begin
        result    = '0;
        exception = 1'b0;
        exc_code  = '0;
        if (done) begin
            if (is_div_q) begin
                if (div_zero_q) begin
                    result = '0;
                end else if (div_ovf_q) begin
                    result = 32'h8000_0000;
                end else begin
                    result = quot_signed;
                end
                exception = div_zero_q | div_ovf_q;
                exc_code  = (div_zero_q | div_ovf_q) ? EXC_DIV : 5'd0;
            end else begin
                result    = prod_signed[31:0];
                exception = mul_ovf;
                exc_code  = mul_ovf ? EXC_MUL_OVF : 5'd0;
            end
        end
    end

    assign ready = done;
    assign busy  = (state_q != ST_IDLE);
    assign stall = start_mul | start_div | busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq with hand-computed expected results.
module tb_muldiv_seq;

    logic        clock;
    logic        resetn;
    logic        start_mul;
    logic        start_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        ready;
    logic        busy;
    logic        stall;
    logic        exception;
    logic [4:0]  exc_code;

    int n_vec = 0;
    int n_err = 0;

    muldiv_seq dut (
        .clock     (clock),
        .resetn    (resetn),
        .start_mul (start_mul),
        .start_div (start_div),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .ready     (ready),
        .busy      (busy),
        .stall     (stall),
        .exception (exception),
        .exc_code  (exc_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one start, then watch until ready; poke_k>0 asserts a stray start_mul in that busy cycle.
    task automatic do_op(input string tag, input logic mul, input logic div,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_res,
                         input logic exp_exc, input logic [4:0] exp_code, input int poke_k);
        int          lat;
        int          busy_cnt;
        int          bad_exc;
        logic        got;
        logic [31:0] res;
        logic        exc;
        logic [4:0]  code;
        lat = 0; busy_cnt = 0; bad_exc = 0; got = 1'b0;
        res = '0; exc = 1'b0; code = '0;
        @(negedge clock);
        start_mul = mul; start_div = div; operand_a = a; operand_b = b;
        @(posedge clock);
        #1;
        start_mul = 1'b0; start_div = 1'b0;
        operand_a = $urandom; operand_b = $urandom;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clock);
            if (busy) busy_cnt++;
            if (ready) begin
                got = 1'b1; lat = k; res = result; exc = exception; code = exc_code;
            end else if (exception || exc_code != 5'd0) begin
                bad_exc++;
            end
            if (poke_k > 0 && k == poke_k) begin
                start_mul = 1'b1; operand_a = 32'd3; operand_b = 32'd3;
            end else if (poke_k > 0 && k == poke_k + 1) begin
                start_mul = 1'b0;
            end
        end
        chk({tag, "_timeout"}, {63'd0, got}, 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        chk({tag, "_result"}, {32'd0, res}, {32'd0, exp_res});
        chk({tag, "_exception"}, {63'd0, exc}, {63'd0, exp_exc});
        chk({tag, "_exc_code"}, {59'd0, code}, {59'd0, exp_code});
        chk({tag, "_exc_idle"}, 64'(bad_exc), 64'd0);
    endtask

    initial begin
        int ready_cnt;
        resetn = 1'b0; start_mul = 1'b0; start_div = 1'b0;
        operand_a = '0; operand_b = '0;
        repeat (2) @(negedge clock);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_exc", {58'd0, exception, exc_code}, 64'd0);
        resetn = 1'b1;

        do_op("mul_7x6",      1, 0, 32'd7,          32'd6,          33, 32'd42,         0, 5'd0, 0);
        do_op("mul_m3x5",     1, 0, 32'hFFFF_FFFD,  32'd5,          33, 32'hFFFF_FFF1,  0, 5'd0, 0);
        do_op("mul_ovf",      1, 0, 32'h0001_0000,  32'h0001_0000,  33, 32'd0,          1, 5'd4, 0);
        do_op("mul_minint",   1, 0, 32'hFFFF_0000,  32'h0000_8000,  33, 32'h8000_0000,  0, 5'd0, 0);
        do_op("mul_posovf",   1, 0, 32'h4000_0000,  32'd2,          33, 32'h8000_0000,  1, 5'd4, 0);
        do_op("div_m7d2",     0, 1, 32'hFFFF_FFF9,  32'd2,          33, 32'hFFFF_FFFD,  0, 5'd0, 0);
        do_op("div_100dm7",   0, 1, 32'd100,        32'hFFFF_FFF9,  33, 32'hFFFF_FFF2,  0, 5'd0, 0);
        do_op("div_by0",      0, 1, 32'd5,          32'd0,          2,  32'd0,          1, 5'd5, 0);
        do_op("div_ovf",      0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  33, 32'h8000_0000,  1, 5'd5, 0);
        do_op("mul_ignore",   1, 0, 32'd100,        32'hFFFF_FFFE,  33, 32'hFFFF_FF38,  0, 5'd0, 10);
        do_op("both_start",   1, 1, 32'd4,          32'd2,          33, 32'd8,          0, 5'd0, 0);

        // Abort an in-flight multiply with a one-cycle reset.
        @(negedge clock);
        start_mul = 1'b1; operand_a = 32'd7; operand_b = 32'd6;
        @(posedge clock);
        #1 start_mul = 1'b0;
        repeat (15) @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ready", {63'd0, ready}, 64'd0);
        start_div = 1'b1;
        #1;
        chk("abort_stall", {63'd0, stall}, 64'd1);
        start_div = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        ready_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clock);
            if (ready) ready_cnt++;
        end
        chk("abort_no_ready", 64'(ready_cnt), 64'd0);
        do_op("div_9d3",      0, 1, 32'd9,          32'd3,          33, 32'd3,          0, 5'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
